// File: rtl/riscv_defs.sv
// Shared RV32I front-end definitions: address/word widths, the fetch buffer
// entry layout and the word-alignment helper.
package riscv_defs;
  localparam int NB_ADDR     = 32;
  localparam int NB_WORD     = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [NB_ADDR-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [NB_ADDR-1:0] pc;
    logic [NB_WORD-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [NB_ADDR-1:0] word_align(input logic [NB_ADDR-1:0] addr);
    return addr & ~NB_ADDR'(INSTR_BYTES - 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetch entries; used both as the instruction buffer and as
// the request-address tag queue.
module fetch_fifo
  import riscv_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word requests,
// buffers in-order returns and hands {pc, instruction} to decode.
module ifetch
  import riscv_defs::*;
#(
  parameter logic [NB_ADDR-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                 DEPTH    = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [NB_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [NB_WORD-1:0] i_imem_rsp_data,
  input  logic               i_redirect,
  input  logic [NB_ADDR-1:0] i_redirect_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_WORD-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_ADDR-1:0] o_pc_plus4
);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state;
  logic [NB_ADDR-1:0] fetch_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      occ;
  logic [CW:0]        credit_use;
  logic               req_fire;
  logic               deq_fire;
  logic               rsp_keep;
  fetch_entry_t       tag_entry;
  fetch_entry_t       tag_head;
  fetch_entry_t       rsp_entry;
  fetch_entry_t       data_head;

  assign o_valid    = (occ != '0);
  assign deq_fire   = o_valid & i_ready;
  // Credit counts buffered plus in-flight entries; a same-cycle dequeue frees a slot.
  assign credit_use = {1'b0, occ} + {1'b0, outstanding} - (CW+1)'(deq_fire);
  assign o_imem_req_valid = (state == ST_RUN) && (credit_use < (CW+1)'(DEPTH));
  assign o_imem_addr      = fetch_pc;
  assign req_fire         = o_imem_req_valid & i_imem_req_ready;
  assign rsp_keep         = i_imem_rsp_valid && (drop_cnt == '0) && !i_redirect;

  assign tag_entry = '{pc: fetch_pc, instruction: '0};

  always_comb begin
    rsp_entry             = tag_head;
    rsp_entry.instruction = i_imem_rsp_data;
  end

  // The tag queue depth doubles as the outstanding-request counter.
  fetch_fifo #(.DEPTH(DEPTH)) u_tag_q (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push      (req_fire),
    .push_data (tag_entry),
    .pop       (i_imem_rsp_valid),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_buf (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (deq_fire),
    .flush     (i_redirect),
    .head      (data_head),
    .count     (occ)
  );

  assign o_instruction = data_head.instruction;
  assign o_pc          = data_head.pc;
  assign o_pc_plus4    = data_head.pc + NB_ADDR'(INSTR_BYTES);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_BOOT;
      fetch_pc <= word_align(RESET_PC);
      drop_cnt <= '0;
    end else begin
      state <= ST_RUN;
      if (i_redirect) begin
        fetch_pc <= word_align(i_redirect_pc);
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding + CW'(req_fire) - CW'(i_imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + NB_ADDR'(INSTR_BYTES);
        if (i_imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with an in-order memory model and a scoreboard of
// expected decode entries.
module tb_ifetch;
  import riscv_defs::*;

  localparam int DEPTH = 4;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic               o_imem_req_valid;
  logic               i_imem_req_ready;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic               i_imem_rsp_valid;
  logic [NB_WORD-1:0] i_imem_rsp_data;
  logic               i_redirect;
  logic [NB_ADDR-1:0] i_redirect_pc;
  logic               o_valid;
  logic               i_ready;
  logic [NB_WORD-1:0] o_instruction;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_ADDR-1:0] o_pc_plus4;

  always #5 i_clock = ~i_clock;

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_instruction    (o_instruction),
    .o_pc             (o_pc),
    .o_pc_plus4       (o_pc_plus4)
  );

  typedef struct { logic [31:0] addr; int due; int ep; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

  pend_t pend[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int epoch = 0;
  int nfire = 0;
  int first_deq_cyc = 0;
  int r_cyc = 0;
  logic        rst_drv = 1'b0, rdy_drv = 1'b1, req_rdy_drv = 1'b1, redir_drv = 1'b0;
  logic [31:0] redir_pc_drv = '0;
  logic [31:0] exp_req_addr = '0;
  logic        obs_req_valid, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_plus4, obs_ins;
  logic        arm_first = 1'b0;
  logic [31:0] first_deq_pc = '0;
  logic        seen_wrap = 1'b0;
  logic [31:0] wrap_plus4 = '0;
  logic        found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0013_0493;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    pend_t       p;
    exp_t        e;
    logic        rsp_driven;
    logic [31:0] rsp_addr;
    int          rsp_ep;
    @(negedge i_clock);
    i_reset          = rst_drv;
    i_ready          = rdy_drv;
    i_imem_req_ready = req_rdy_drv;
    i_redirect       = redir_drv;
    i_redirect_pc    = redir_pc_drv;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    rsp_driven = 1'b0;
    rsp_addr   = '0;
    rsp_ep     = 0;
    if (rst_drv && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(p.addr);
      rsp_driven = 1'b1;
      rsp_addr   = p.addr;
      rsp_ep     = p.ep;
    end
    #1;
    obs_req_valid = o_imem_req_valid;
    obs_addr      = o_imem_addr;
    obs_valid     = o_valid;
    obs_pc        = o_pc;
    obs_plus4     = o_pc_plus4;
    obs_ins       = o_instruction;
    if (rsp_driven && rsp_ep == epoch && !redir_drv)
      exp_q.push_back('{pc: rsp_addr, ins: mem_word(rsp_addr)});
    if (o_imem_req_valid && i_imem_req_ready) begin
      check("req_addr", o_imem_addr, exp_req_addr);
      pend.push_back('{addr: o_imem_addr, due: cyc + lat, ep: epoch});
      exp_req_addr = exp_req_addr + 32'd4;
      nfire++;
    end
    if (o_valid && i_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_deq observed pc=%h expected no entry", o_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("deq_pc", o_pc, e.pc);
        check("deq_ins", o_instruction, e.ins);
        check("deq_pc_plus4", o_pc_plus4, e.pc + 32'd4);
      end
      if (arm_first) begin
        first_deq_pc  = o_pc;
        first_deq_cyc = cyc;
        arm_first     = 1'b0;
      end
      if (o_pc == 32'hFFFF_FFFC) begin
        seen_wrap  = 1'b1;
        wrap_plus4 = o_pc_plus4;
      end
    end
    if (redir_drv) begin
      epoch++;
      exp_q.delete();
      exp_req_addr = redir_pc_drv & ~32'h3;
    end
    cyc++;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redir_drv    = 1'b1;
    redir_pc_drv = pc;
    tick();
    redir_drv = 1'b0;
  endtask

  task automatic clear_model();
    pend.delete();
    exp_q.delete();
    epoch++;
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b0;
    clear_model();
    repeat (n) tick();
    rst_drv      = 1'b1;
    exp_req_addr = 32'h0000_0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = '0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_ready = 1'b1;
    #1 i_reset = 1'b0;

    // Reset values and first stream at latency 1.
    do_reset(3);
    check("rst_valid", obs_valid, 1'b0);
    check("rst_req_valid", obs_req_valid, 1'b0);
    check("rst_addr", obs_addr, 32'h0);
    check("rst_ins", obs_ins, 32'h0);
    check("rst_pc", obs_pc, 32'h0);
    check("rst_pc_plus4", obs_plus4, 32'h4);
    tick();
    check("boot_req_valid", obs_req_valid, 1'b0);
    tick();
    check("c2_req_valid", obs_req_valid, 1'b1);
    check("c2_addr", obs_addr, 32'h0);
    tick();
    check("c3_addr", obs_addr, 32'h4);
    check("c3_valid", obs_valid, 1'b0);
    tick();
    check("c4_addr", obs_addr, 32'h8);
    check("c4_valid", obs_valid, 1'b1);
    check("c4_pc", obs_pc, 32'h0);
    check("c4_pc_plus4", obs_plus4, 32'h4);
    tick();
    check("c5_valid", obs_valid, 1'b1);
    check("c5_pc", obs_pc, 32'h4);
    check("c5_pc_plus4", obs_plus4, 32'h8);
    repeat (6) tick();

    // Decode stalled from reset: exactly DEPTH entries, no extra request.
    rdy_drv = 1'b0;
    do_reset(2);
    nfire = 0;
    repeat (10) tick();
    check("stall_fires", nfire, DEPTH);
    check("stall_buffered", exp_q.size(), DEPTH);
    check("stall_valid", obs_valid, 1'b1);
    check("stall_req_valid", obs_req_valid, 1'b0);
    check("stall_head_pc", obs_pc, 32'h0);
    rdy_drv = 1'b1;
    repeat (8) tick();

    // Latency 3, two requests outstanding, redirect to 0x100.
    lat = 3;
    req_rdy_drv = 1'b0;
    repeat (8) tick();
    req_rdy_drv = 1'b1;
    tick();
    tick();
    req_rdy_drv = 1'b0;
    r_cyc = cyc;
    redirect(32'h0000_0100);
    req_rdy_drv = 1'b1;
    arm_first = 1'b1;
    tick();
    check("r1_valid", obs_valid, 1'b0);
    check("r1_req_valid", obs_req_valid, 1'b1);
    check("r1_addr", obs_addr, 32'h100);
    for (int k = 0; k < 20 && arm_first; k++) tick();
    check("r1_first_timeout", arm_first, 1'b0);
    check("r1_first_pc", first_deq_pc, 32'h100);
    check("r1_first_cycle", first_deq_cyc, r_cyc + 5);

    // Redirect to an unaligned target while a response lands in the same cycle.
    rdy_drv = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      found = (exp_q.size() >= 2) && (pend.size() > 0) && (pend[0].due <= cyc);
    end
    check("r2_setup", found, 1'b1);
    redirect(32'h0000_0203);
    rdy_drv = 1'b1;
    arm_first = 1'b1;
    tick();
    check("r2_valid", obs_valid, 1'b0);
    check("r2_req_valid", obs_req_valid, 1'b1);
    check("r2_addr", obs_addr, 32'h200);
    for (int k = 0; k < 20 && arm_first; k++) tick();
    check("r2_first_timeout", arm_first, 1'b0);
    check("r2_first_pc", first_deq_pc, 32'h200);

    // Address wrap at the top of the space.
    lat = 1;
    seen_wrap = 1'b0;
    redirect(32'hFFFF_FFF4);
    for (int k = 0; k < 20 && !seen_wrap; k++) tick();
    check("wrap_seen", seen_wrap, 1'b1);
    check("wrap_pc_plus4", wrap_plus4, 32'h0);
    repeat (3) tick();

    // Asynchronous reset with three entries buffered.
    rdy_drv = 1'b0;
    redirect(32'h0000_0040);
    for (int k = 0; k < 20 && exp_q.size() != 3; k++) tick();
    check("ar_buffered", exp_q.size(), 3);
    check("ar_pre_valid", o_valid, 1'b1);
    rst_drv = 1'b0;
    i_reset = 1'b0;
    #1;
    check("ar_valid", o_valid, 1'b0);
    check("ar_req_valid", o_imem_req_valid, 1'b0);
    check("ar_addr", o_imem_addr, 32'h0);
    rdy_drv = 1'b1;
    req_rdy_drv = 1'b1;
    do_reset(2);
    tick();
    check("ar_boot_req_valid", obs_req_valid, 1'b0);
    tick();
    check("ar_req_valid_c2", obs_req_valid, 1'b1);
    check("ar_addr_c2", obs_addr, 32'h0);
    repeat (8) tick();
    check("ar_stream_pc", obs_pc, 32'h18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
